// File: rtl/rv32_bus_arbiter.sv
// ============================================================================
// Module   : rv32_bus_arbiter
// Brief    : Shares one memory bus between the fetch and load/store ports.
//            Data has priority, but a waiting fetch is forced through after
//            a bounded number of consecutive data completions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32_bus_arbiter #(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_address_in,
  input  logic        instr_read_in,
  output logic [31:0] instr_read_value_out,
  output logic        instr_ready_out,
  input  logic [31:0] data_address_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_write_value_in,
  output logic [31:0] data_read_value_out,
  output logic        data_ready_out,
  output logic [31:0] bus_address_out,
  output logic        bus_read_out,
  output logic        bus_write_out,
  output logic [3:0]  bus_write_mask_out,
  output logic [31:0] bus_write_value_out,
  input  logic [31:0] bus_read_value_in,
  input  logic        bus_ready_in,
  output logic [1:0]  grant_out
);

  localparam int CNT_W = $clog2(MAX_DATA_BURST + 1);
  localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_DATA_BURST);

  localparam logic [1:0] c_own_none  = 2'b00;
  localparam logic [1:0] c_own_instr = 2'b01;
  localparam logic [1:0] c_own_data  = 2'b10;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOCK_INSTR = 2'd1,
    LOCK_DATA  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [1:0]       w_owner;
  logic             w_data_req;
  logic             w_instr_done;
  logic             w_data_done;

  assign w_data_req = data_read_in | data_write_in;

  // A locked owner that drops its request aborts: nobody owns the bus.
  always_comb begin
    w_owner = c_own_none;
    case (r_state)
      LOCK_INSTR: w_owner = instr_read_in ? c_own_instr : c_own_none;
      LOCK_DATA:  w_owner = w_data_req    ? c_own_data  : c_own_none;
      default: begin
        if (instr_read_in && w_data_req)
          w_owner = (r_starve_cnt == c_max_cnt) ? c_own_instr : c_own_data;
        else if (instr_read_in)
          w_owner = c_own_instr;
        else if (w_data_req)
          w_owner = c_own_data;
      end
    endcase
    if (reset)
      w_owner = c_own_none;
  end

  assign w_instr_done = (w_owner == c_own_instr) & bus_ready_in;
  assign w_data_done  = (w_owner == c_own_data)  & bus_ready_in;

  always_comb begin
    bus_address_out     = '0;
    bus_read_out        = 1'b0;
    bus_write_out       = 1'b0;
    bus_write_mask_out  = '0;
    bus_write_value_out = '0;
    if (w_owner == c_own_instr) begin
      bus_address_out = instr_address_in;
      bus_read_out    = 1'b1;
    end else if (w_owner == c_own_data) begin
      bus_address_out     = data_address_in;
      bus_read_out        = data_read_in;
      bus_write_out       = data_write_in;
      bus_write_mask_out  = data_write_mask_in;
      bus_write_value_out = data_write_value_in;
    end
  end

  assign instr_ready_out      = w_instr_done;
  assign data_ready_out       = w_data_done;
  assign instr_read_value_out = bus_read_value_in;
  assign data_read_value_out  = bus_read_value_in;
  assign grant_out            = w_owner;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (!bus_ready_in && w_owner == c_own_instr)
          w_state_next = LOCK_INSTR;
        else if (!bus_ready_in && w_owner == c_own_data)
          w_state_next = LOCK_DATA;
      end
      LOCK_INSTR, LOCK_DATA: begin
        if (bus_ready_in || w_owner == c_own_none)
          w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (!instr_read_in || w_instr_done)
        r_starve_cnt <= '0;
      else if (w_data_done && r_starve_cnt != c_max_cnt)
        r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire
